// File: rtl/bfs_xbar_pkg.sv
// ============================================================================
// Module  : bfs_xbar_pkg
// Brief   : Shared constants and helpers for the BFS frontier crossbar.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bfs_xbar_pkg;

    localparam int DEF_NUM_PU     = 16;
    localparam int DEF_NODE_BITS  = 32;
    localparam int DEF_FIFO_DEPTH = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Hash destination with optional victim->thief redirect; a self-redirect is a no-op.
    function automatic logic [31:0] route(
        input logic [31:0] dest,
        input logic        steal_en,
        input logic [31:0] steal_from,
        input logic [31:0] steal_to
    );
        logic [31:0] r;
        r = dest;
        if (steal_en && (dest == steal_from) && (steal_from != steal_to)) begin
            r = steal_to;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin arbiter; searches from ptr+1 cyclically.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import bfs_xbar_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] w_cand;
    logic          w_found;

    // N is a power of two, so the IW-bit add wraps exactly modulo N.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int i = 1; i <= N; i++) begin
            w_cand = ptr + IW'(i);
            if (!w_found && req[w_cand]) begin
                w_found       = 1'b1;
                grant[w_cand] = 1'b1;
                grant_idx     = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/frontier_xbar_buffered.sv
// ============================================================================
// Module  : frontier_xbar_buffered
// Brief   : Buffered frontier crossbar: per-input FIFOs, hash routing with a
//           steal redirect, per-output round-robin and registered outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module frontier_xbar_buffered
    import bfs_xbar_pkg::*;
#(
    parameter  int NUM_PU     = DEF_NUM_PU,
    parameter  int NODE_BITS  = DEF_NODE_BITS,
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int IDX_W      = idx_width(NUM_PU)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PU*NODE_BITS-1:0] in_data,
    input  logic [NUM_PU-1:0]           in_valid,
    output logic [NUM_PU-1:0]           in_ready,
    output logic [NUM_PU*NODE_BITS-1:0] out_data,
    output logic [NUM_PU-1:0]           out_valid,
    input  logic [NUM_PU-1:0]           out_ready,
    input  logic                        steal_en,
    input  logic [IDX_W-1:0]            steal_from,
    input  logic [IDX_W-1:0]            steal_to,
    output logic [NUM_PU-1:0]           fifo_full,
    output logic                        idle
);

    localparam int              PTR_W  = $clog2(FIFO_DEPTH);
    localparam int              CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FIFO_DEPTH);

    logic [NODE_BITS-1:0] w_head      [NUM_PU];
    logic [IDX_W-1:0]     w_dest      [NUM_PU];
    logic [NUM_PU-1:0]    w_req       [NUM_PU];
    logic [NUM_PU-1:0]    w_grant     [NUM_PU];
    logic [IDX_W-1:0]     w_grant_idx [NUM_PU];
    logic [NUM_PU-1:0]    w_empty;
    logic [NUM_PU-1:0]    w_full;
    logic [NUM_PU-1:0]    w_pop;
    logic [NUM_PU-1:0]    w_can_load;

    logic [NUM_PU-1:0]    r_out_valid;
    logic [NODE_BITS-1:0] r_out_data  [NUM_PU];
    logic [IDX_W-1:0]     r_ptr       [NUM_PU];

    for (genvar k = 0; k < NUM_PU; k++) begin : g_fifo
        logic [NODE_BITS-1:0] r_mem [FIFO_DEPTH];
        logic [PTR_W-1:0]     r_rd_ptr;
        logic [PTR_W-1:0]     r_wr_ptr;
        logic [CNT_W-1:0]     r_count;
        logic                 w_push;

        // A full FIFO refuses the push even when its head pops this cycle.
        assign w_full[k]  = (r_count == C_FULL);
        assign w_empty[k] = (r_count == '0);
        assign w_push     = in_valid[k] && !w_full[k];
        assign w_head[k]  = r_mem[r_rd_ptr];

        // Routed from the live head, so steal changes retarget buffered items.
        assign w_dest[k] = IDX_W'(route(32'(w_head[k][IDX_W-1:0]), steal_en,
                                        32'(steal_from), 32'(steal_to)));

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data[k*NODE_BITS +: NODE_BITS];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop[k]) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop[k]})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_PU; j++) begin
            w_req[j] = '0;
            for (int k = 0; k < NUM_PU; k++) begin
                w_req[j][k] = !w_empty[k] && (w_dest[k] == IDX_W'(j));
            end
        end
    end

    // Each head has a single destination, so grants never collide across outputs.
    always_comb begin
        w_pop = '0;
        for (int j = 0; j < NUM_PU; j++) begin
            if (w_can_load[j]) begin
                w_pop = w_pop | w_grant[j];
            end
        end
    end

    for (genvar j = 0; j < NUM_PU; j++) begin : g_out
        assign w_can_load[j] = !r_out_valid[j] || out_ready[j];

        rr_arbiter #(
            .N  (NUM_PU),
            .IW (IDX_W)
        ) u_arb (
            .req       (w_req[j]),
            .ptr       (r_ptr[j]),
            .grant     (w_grant[j]),
            .grant_idx (w_grant_idx[j])
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_out_valid[j] <= 1'b0;
                r_out_data[j]  <= '0;
                r_ptr[j]       <= IDX_W'(NUM_PU - 1);
            end else if (w_can_load[j]) begin
                if (|w_req[j]) begin
                    r_out_valid[j] <= 1'b1;
                    r_out_data[j]  <= w_head[w_grant_idx[j]];
                    r_ptr[j]       <= w_grant_idx[j];
                end else begin
                    r_out_valid[j] <= 1'b0;
                end
            end
        end

        assign out_data[j*NODE_BITS +: NODE_BITS] = r_out_data[j];
    end

    assign out_valid = r_out_valid;
    assign in_ready  = ~w_full;
    assign fifo_full = w_full;
    assign idle      = (&w_empty) && (r_out_valid == '0);

endmodule

`default_nettype wire

// File: tb/tb_frontier_xbar_buffered.sv
// ============================================================================
// Module  : tb_frontier_xbar_buffered
// Brief   : Scoreboard bench for frontier_xbar_buffered (4 PUs, 32-bit IDs).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frontier_xbar_buffered;

    localparam int NP = 4;
    localparam int NB = 32;
    localparam int FD = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NP*NB-1:0] in_data;
    logic [NP-1:0]    in_valid;
    logic [NP-1:0]    in_ready;
    logic [NP*NB-1:0] out_data;
    logic [NP-1:0]    out_valid;
    logic [NP-1:0]    out_ready;
    logic             steal_en;
    logic [1:0]       steal_from;
    logic [1:0]       steal_to;
    logic [NP-1:0]    fifo_full;
    logic             idle;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q [NP][$];

    always #5 clk = ~clk;

    frontier_xbar_buffered #(
        .NUM_PU     (NP),
        .NODE_BITS  (NB),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .steal_en   (steal_en),
        .steal_from (steal_from),
        .steal_to   (steal_to),
        .fifo_full  (fifo_full),
        .idle       (idle)
    );

    // Node ID: tag | source | sequence | low two bits = hash destination.
    function automatic logic [31:0] mk(input logic [7:0] tag, input int src,
                                       input int seq, input logic [1:0] dest);
        return {tag, 8'(src), 12'(seq), 2'b00, dest};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every accepted output beat must match the head of its queue.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                for (int j = 0; j < NP; j++) begin
                    if (out_valid[j] && out_ready[j]) begin
                        if (exp_q[j].size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_out%0d: got 0x%08h, expected nothing",
                                     j, out_data[j*NB +: NB]);
                        end else begin
                            e = exp_q[j].pop_front();
                            chk($sformatf("out%0d_data", j), out_data[j*NB +: NB], e);
                        end
                    end
                end
            end
        end
    end

    task automatic stream(input logic [3:0] mask, input int n, input logic [1:0] dest,
                          input bit self_dest, input logic [7:0] tag);
        int          seq [NP];
        logic [NP-1:0] go;
        int          guard;
        bit          busy;
        for (int k = 0; k < NP; k++) seq[k] = 0;
        guard = 0;
        forever begin
            @(negedge clk);
            busy = 1'b0;
            for (int k = 0; k < NP; k++) begin
                if (mask[k] && seq[k] < n) begin
                    in_valid[k] = 1'b1;
                    in_data[k*NB +: NB] = mk(tag, k, seq[k], self_dest ? 2'(k) : dest);
                    busy = 1'b1;
                end else begin
                    in_valid[k] = 1'b0;
                end
            end
            if (!busy || guard >= 200) break;
            go = in_valid & in_ready;
            @(posedge clk);
            for (int k = 0; k < NP; k++) if (go[k]) seq[k]++;
            guard++;
        end
        in_valid = '0;
        n_tests++;
        if (guard >= 200) begin
            n_fail++;
            $display("FAIL stream_timeout: got %0d cycles, expected under 200", guard);
        end
    endtask

    task automatic send_one(input int k, input logic [31:0] d);
        int g;
        g = 0;
        @(negedge clk);
        in_valid[k] = 1'b1;
        in_data[k*NB +: NB] = d;
        while (!in_ready[k] && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        in_valid[k] = 1'b0;
        n_tests++;
        if (g >= 50) begin
            n_fail++;
            $display("FAIL send_timeout: got %0d cycles, expected under 50", g);
        end
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while (((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
                || !idle) && g < 200) begin
            @(negedge clk);
            g++;
        end
        n_tests++;
        if (g >= 200) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d cycles, expected under 200", name, g);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid   = '0;
        in_data    = '0;
        out_ready  = 4'b1111;
        steal_en   = 1'b0;
        steal_from = 2'd0;
        steal_to   = 2'd0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'hF);
        chk("rst_fifo_full", 32'(fifo_full), 32'h0);
        chk("rst_idle",      32'(idle),      32'h1);
        chk("rst_out_data0", out_data[31:0], 32'h0);

        // Latency: input 1 sends 0x6 (dest 2), visible after the second edge.
        @(negedge clk);
        in_valid[1] = 1'b1;
        in_data[1*NB +: NB] = 32'h6;
        exp_q[2].push_back(32'h6);
        @(negedge clk);
        in_valid = '0;
        chk("lat_idle_e0",  32'(idle),      32'h0);
        chk("lat_valid_e0", 32'(out_valid), 32'h0);
        @(negedge clk);
        chk("lat_valid_e1", 32'(out_valid), 32'b0100);
        chk("lat_data_e1",  out_data[2*NB +: NB], 32'h6);
        chk("lat_idle_e1",  32'(idle),      32'h0);
        drain("lat");
        chk("lat_idle_end", 32'(idle), 32'h1);

        // Fairness: inputs 0, 1, 3 all target output 1; grants rotate 0,1,3.
        for (int s = 0; s < 3; s++) begin
            exp_q[1].push_back(mk(8'h11, 0, s, 2'd1));
            exp_q[1].push_back(mk(8'h11, 1, s, 2'd1));
            exp_q[1].push_back(mk(8'h11, 3, s, 2'd1));
        end
        fork
            stream(4'b1011, 3, 2'd1, 1'b0, 8'h11);
            begin
                int g;
                g = 0;
                while (!out_valid[1] && g < 20) begin
                    @(negedge clk);
                    g++;
                end
                for (int c = 0; c < 9; c++) begin
                    chk("fair_no_gap", 32'(out_valid[1]), 32'h1);
                    @(negedge clk);
                end
            end
        join
        drain("fair");

        // Backpressure: output 2 stalled, input 0 offers six IDs; five fit.
        @(negedge clk);
        out_ready[2] = 1'b0;
        for (int s = 0; s < 6; s++) exp_q[2].push_back(mk(8'h22, 0, s, 2'd2));
        fork
            stream(4'b0001, 6, 2'd2, 1'b0, 8'h22);
            begin
                repeat (8) @(negedge clk);
                chk("bp_fifo_full", 32'(fifo_full[0]), 32'h1);
                chk("bp_in_ready",  32'(in_ready[0]),  32'h0);
                chk("bp_out_valid", 32'(out_valid[2]), 32'h1);
                chk("bp_out_hold",  out_data[2*NB +: NB], mk(8'h22, 0, 0, 2'd2));
                chk("bp_idle",      32'(idle), 32'h0);
                out_ready[2] = 1'b1;
            end
        join
        drain("bp");

        // Steal: dest 3 redirected to 0; then a self-redirect is ignored.
        @(negedge clk);
        steal_en   = 1'b1;
        steal_from = 2'd3;
        steal_to   = 2'd0;
        exp_q[0].push_back(32'h7);
        send_one(2, 32'h7);
        drain("steal");
        steal_to = 2'd3;
        exp_q[3].push_back(32'h7);
        send_one(2, 32'h7);
        drain("steal_self");
        steal_en = 1'b0;

        // Mid-operation reset: fill every path, reset, nothing may survive.
        @(negedge clk);
        out_ready = 4'b0000;
        stream(4'b1111, 5, 2'd0, 1'b1, 8'h44);
        chk("mr_fifo_full", 32'(fifo_full), 32'hF);
        chk("mr_out_valid", 32'(out_valid), 32'hF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_valid_cleared", 32'(out_valid), 32'h0);
        chk("mr_idle",          32'(idle),      32'h1);
        chk("mr_in_ready",      32'(in_ready),  32'hF);
        out_ready = 4'b1111;
        repeat (10) @(negedge clk);
        chk("mr_still_idle",    32'(idle),      32'h1);

        chk("queues_empty", 32'(exp_q[0].size() + exp_q[1].size()
                                + exp_q[2].size() + exp_q[3].size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
